// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types. Holds the receiver line-state encoding and
//               the packet-assembler state encoding used by uart_rx_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver line states (owned by the UART receiver front end)
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Packet assembler states
  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_DISCARD = 2'd2
  } asm_state_t;

  // Bit counter must reach n_bits+1 so an over-long packet is recognisable
  function automatic int cnt_width(input int n_bits);
    return $clog2(n_bits + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer_if
// Description : Bit-stream input and word-stream output bundle of the UART
//               receive buffer. master = receiver/consumer side,
//               slave = the buffer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_buffer_if #(
  parameter int n_bits = 8,
  parameter int depth  = 4
) ();

  localparam int FILL_W = $clog2(depth + 1);

  logic              rx_bit;
  logic              rx_bit_ready;
  logic              rx_packet_complete;
  logic              rx_packet_successfull;
  logic [n_bits-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [FILL_W-1:0] fill;
  logic              frame_error;
  logic              overflow;
  logic              clear_errors;

  modport master (
    output rx_bit, rx_bit_ready, rx_packet_complete, rx_packet_successfull,
    output out_ready, clear_errors,
    input  out_data, out_valid, fill, frame_error, overflow
  );

  modport slave (
    input  rx_bit, rx_bit_ready, rx_packet_complete, rx_packet_successfull,
    input  out_ready, clear_errors,
    output out_data, out_valid, fill, frame_error, overflow
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word fall-through FIFO. A push into a full
//               FIFO is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(depth+1)-1:0]   fill_o
);

  localparam int PTR_W  = $clog2(depth);
  localparam int FILL_W = $clog2(depth + 1);

  logic [width-1:0]  mem_q [depth];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (fill_q == '0);
  assign full_o  = (fill_q == FILL_W'(depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Output is forced to zero while empty so stale storage never shows
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign fill_o  = fill_q;

  // Storage array; contents are don't-care until covered by fill
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer
// Description : Assembles LSB-first UART data bits into words, validates the
//               bit count and stop bit, and queues good words in a FIFO.
//               Bad packets pulse frame_error; a good packet lost to a full
//               FIFO sets the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int n_bits = 8,
  parameter int depth  = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_buffer_if.slave  bus
);

  localparam int CNT_W  = cnt_width(n_bits);
  localparam int FILL_W = $clog2(depth + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(n_bits);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(n_bits + 1);

  asm_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [n_bits-1:0] shift_q;
  logic              push_q;
  logic [n_bits-1:0] push_data_q;
  logic              frame_error_q;
  logic              overflow_q;

  logic              bit_take;
  logic [CNT_W-1:0]  cnt_d;
  logic [n_bits-1:0] shift_d;
  logic              good_d;
  logic              overflow_set;

  logic [n_bits-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FILL_W-1:0] fifo_fill;

  // Bits are ignored once the packet is known to be too long
  assign bit_take = bus.rx_bit_ready && (state_q != ASM_DISCARD);
  assign cnt_d    = bit_take ? (cnt_q + CNT_W'(1)) : cnt_q;

  // New bit enters at the MSB so the first bit lands in bit 0 when full
  generate
    if (n_bits == 1) begin : g_shift_single
      assign shift_d = bit_take ? bus.rx_bit : shift_q;
    end else begin : g_shift_multi
      assign shift_d = bit_take ? {bus.rx_bit, shift_q[n_bits-1:1]} : shift_q;
    end
  endgenerate

  // A coincident bit is already folded into cnt_d/shift_d here
  assign good_d = bus.rx_packet_successfull
                  && (state_q != ASM_DISCARD)
                  && (cnt_d == CNT_FULL);

  // Assembler FSM; decision for a closing packet is registered as push/error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ASM_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
      frame_error_q <= 1'b0;
    end else begin
      push_q        <= 1'b0;
      frame_error_q <= 1'b0;
      if (bus.rx_packet_complete) begin
        state_q       <= ASM_IDLE;
        cnt_q         <= '0;
        shift_q       <= '0;
        push_q        <= good_d;
        frame_error_q <= !good_d;
        push_data_q   <= shift_d;
      end else if (bit_take) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
        state_q <= (cnt_d == CNT_OVER) ? ASM_DISCARD : ASM_COLLECT;
      end
    end
  end

  sync_fifo #(
    .width (n_bits),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i (push_data_q),
    .pop_i   (bus.out_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fifo_fill)
  );

  // A full FIFO still accepts a write when the consumer pops that cycle
  assign overflow_set = push_q && fifo_full && !bus.out_ready;

  // Sticky overflow; a fresh overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (overflow_set) begin
      overflow_q <= 1'b1;
    end else if (bus.clear_errors) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.out_data    = fifo_rdata;
  assign bus.out_valid   = !fifo_empty;
  assign bus.fill        = fifo_fill;
  assign bus.frame_error = frame_error_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Self-checking bench for uart_rx_buffer: directed scenarios
//               plus randomized packets against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

  localparam int N_BITS = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_buffer_if #(.n_bits(N_BITS), .depth(DEPTH)) bus ();

  uart_rx_buffer #(.n_bits(N_BITS), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit rand_mode = 1'b0;
  logic ordy = 1'b0;

  // Reference model: words waiting in the FIFO, bits of the open packet
  logic [N_BITS-1:0] m_q[$];
  bit                m_cur[$];
  bit                m_pend = 1'b0;
  logic [N_BITS-1:0] m_pend_d = '0;
  bit                m_fe = 1'b0;
  bit                m_ovf = 1'b0;
  bit                m_pop;
  bit                m_setovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_cur.delete();
      m_pend = 1'b0;
      m_fe   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_pop    = (m_q.size() > 0) && bus.out_ready;
      m_setovf = 1'b0;
      if (m_pop) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pend_d);
        else m_setovf = 1'b1;
      end
      if (m_setovf) m_ovf = 1'b1;
      else if (bus.clear_errors) m_ovf = 1'b0;
      m_pend = 1'b0;
      m_fe   = 1'b0;
      if (bus.rx_bit_ready) m_cur.push_back(bus.rx_bit);
      if (bus.rx_packet_complete) begin
        if (bus.rx_packet_successfull && m_cur.size() == N_BITS) begin
          m_pend   = 1'b1;
          m_pend_d = '0;
          for (int i = 0; i < N_BITS; i++) m_pend_d[i] = m_cur[i];
        end else begin
          m_fe = 1'b1;
        end
        m_cur.delete();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [N_BITS-1:0] exp_d;
    exp_d = (m_q.size() != 0) ? m_q[0] : '0;
    chk("fill",  32'(bus.fill), m_q.size());
    chk("valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("data",  32'(bus.out_data), 32'(exp_d));
    chk("ferr",  32'(bus.frame_error), 32'(m_fe));
    chk("ovf",   32'(bus.overflow), 32'(m_ovf));
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs
  task automatic cyc(input logic rb, input logic b, input logic cmp, input logic succ, input logic clr);
    logic c;
    c = clr;
    @(negedge clk);
    compare_model();
    if (rand_mode) begin
      ordy = 1'($urandom_range(0, 1));
      c    = c | ($urandom_range(0, 15) == 0);
    end
    bus.rx_bit_ready          = rb;
    bus.rx_bit                = b;
    bus.rx_packet_complete    = cmp;
    bus.rx_packet_successfull = succ;
    bus.clear_errors          = c;
    bus.out_ready             = ordy;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_ready(input logic v);
    ordy          = v;
    bus.out_ready = v;
  endtask

  task automatic send_pkt(input int nb, input logic [31:0] d, input logic succ,
                          input bit coinc, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      if (coinc && i == nb - 1) cyc(1'b1, d[i], 1'b1, succ, 1'b0);
      else cyc(1'b1, d[i], 1'b0, 1'b0, 1'b0);
    end
    if (!(coinc && nb > 0)) cyc(1'b0, 1'b0, 1'b1, succ, 1'b0);
  endtask

  task automatic drain_expect(input logic [7:0] first, input int n);
    set_ready(1'b1);
    for (int k = 0; k < n; k++) begin
      chk("drain_data", 32'(bus.out_data), 32'(first + 8'(k)));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    set_ready(1'b0);
  endtask

  initial begin
    rst = 1'b0;
    bus.rx_bit = 1'b0;
    bus.rx_bit_ready = 1'b0;
    bus.rx_packet_complete = 1'b0;
    bus.rx_packet_successfull = 1'b0;
    bus.clear_errors = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fill",  32'(bus.fill), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data), 0);
    chk("rst_ferr",  32'(bus.frame_error), 0);
    chk("rst_ovf",   32'(bus.overflow), 0);
    rst = 1'b1;
    idle(2);

    // 0,1,0,1,0,0,1,1 LSB first -> 0xCA, visible two cycles after completion
    send_pkt(8, 32'hCA, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("ca_valid_early", 32'(bus.out_valid), 0);
    chk("ca_ferr", 32'(bus.frame_error), 0);
    idle(1);
    chk("ca_valid", 32'(bus.out_valid), 1);
    chk("ca_data", 32'(bus.out_data), 32'hCA);
    drain_expect(8'hCA, 1);
    idle(1);

    // bad stop bit
    send_pkt(8, 32'h3C, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("stop_ferr", 32'(bus.frame_error), 1);
    idle(1);
    chk("stop_ferr_off", 32'(bus.frame_error), 0);
    chk("stop_fill", 32'(bus.fill), 0);

    // short and long packets, then a good 0x55
    send_pkt(7, 32'h7F, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("short_ferr", 32'(bus.frame_error), 1);
    send_pkt(9, 32'h1FF, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("long_ferr", 32'(bus.frame_error), 1);
    idle(1);
    chk("long_fill", 32'(bus.fill), 0);
    send_pkt(8, 32'h55, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("p55_data", 32'(bus.out_data), 32'h55);
    chk("p55_fill", 32'(bus.fill), 1);
    drain_expect(8'h55, 1);
    idle(1);

    // overflow with five packets into a depth-4 FIFO
    for (int k = 1; k <= 5; k++) send_pkt(8, 32'(k), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("ovf_fill", 32'(bus.fill), 4);
    chk("ovf_flag", 32'(bus.overflow), 1);
    drain_expect(8'h01, 4);
    idle(1);
    chk("ovf_empty", 32'(bus.fill), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("ovf_cleared", 32'(bus.overflow), 0);

    // full FIFO: write coincides with a pop
    for (int k = 0; k < 4; k++) send_pkt(8, 32'(8'h10 + 8'(k)), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("full_fill", 32'(bus.fill), 4);
    send_pkt(8, 32'h14, 1'b1, 1'b0, 1'b0);
    idle(1);
    set_ready(1'b1);
    idle(1);
    set_ready(1'b0);
    chk("pp_fill", 32'(bus.fill), 4);
    chk("pp_ovf", 32'(bus.overflow), 0);
    drain_expect(8'h11, 4);
    idle(1);

    // asynchronous reset mid-packet with two words buffered
    send_pkt(8, 32'h21, 1'b1, 1'b0, 1'b0);
    send_pkt(8, 32'h22, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("pre_rst_fill", 32'(bus.fill), 2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'(i & 1), 1'b0, 1'b0, 1'b0);
    bus.rx_bit_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_fill",  32'(bus.fill), 0);
    chk("arst_data",  32'(bus.out_data), 0);
    chk("arst_ferr",  32'(bus.frame_error), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send_pkt(8, 32'hA5, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("a5_ferr", 32'(bus.frame_error), 0);
    idle(1);
    chk("a5_data", 32'(bus.out_data), 32'hA5);
    chk("a5_fill", 32'(bus.fill), 1);
    drain_expect(8'hA5, 1);
    idle(1);

    // randomized packets, lengths, stop bits, consumer stalls and clears
    rand_mode = 1'b1;
    for (int p = 0; p < 80; p++) begin
      int r;
      int nb;
      r = $urandom_range(0, 9);
      case (r)
        0:       nb = 7;
        1:       nb = 9;
        2:       nb = $urandom_range(0, 12);
        default: nb = 8;
      endcase
      send_pkt(nb, $urandom, 1'($urandom_range(0, 7) != 0),
               $urandom_range(0, 3) == 0, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    rand_mode = 1'b0;
    set_ready(1'b1);
    idle(10);
    chk("end_fill", 32'(bus.fill), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 The block SHALL have parameter n_bits, default 8, meaning data bits per packet (1..16).
REQ-002 The block SHALL have parameter depth, default 4, meaning FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock shared with the UART receiver.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Port rx_bit  input  1  sampled bit value from the receiver.
REQ-007 Port rx_bit_ready  input  1  one-cycle strobe; rx_bit is valid this cycle.
REQ-008 Port rx_packet_complete  input  1  one-cycle strobe; stop bit processed.
REQ-009 Port rx_packet_successfull  input  1  qualifies rx_packet_complete; 1 = stop bit good.
REQ-010 Port out_data  output  n_bits  head-of-FIFO word, first-word fall-through.
REQ-011 Port out_valid  output  1  FIFO not empty.
REQ-012 Port out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-013 Port fill  output  $clog2(depth+1)  current FIFO occupancy.
REQ-014 Port frame_error  output  1  one-cycle pulse; packet dropped (bad stop or wrong bit count).
REQ-015 Port overflow  output  1  sticky; a good packet was dropped because the FIFO was full.
REQ-016 Port clear_errors  input  1  one-cycle strobe; clears overflow.

Function
REQ-017 The assembler SHALL be a state machine with states IDLE, COLLECT, DISCARD.
REQ-018 IDLE -> COLLECT on rx_bit_ready; COLLECT -> DISCARD on the (n_bits+1)-th rx_bit_ready; any state -> IDLE on rx_packet_complete.
REQ-019 On each rx_bit_ready in IDLE/COLLECT, the bit SHALL shift in LSB-first (new bit enters the MSB, register shifts right) and bit_cnt SHALL increment.
REQ-020 In DISCARD, rx_bit_ready SHALL be ignored and bit_cnt SHALL hold.
REQ-021 If rx_bit_ready and rx_packet_complete coincide, the bit SHALL count toward the closing packet before the completion is evaluated.
REQ-022 On rx_packet_complete, a packet SHALL be good only if rx_packet_successfull = 1, the state is not DISCARD, and bit_cnt (including any coincident bit) = n_bits.
REQ-023 A good packet SHALL be written to the FIFO on the clock edge after the completion strobe; it is visible on out_data/out_valid one cycle after that write.
REQ-024 A bad packet SHALL assert frame_error for exactly one cycle, coincident with the would-be write, and SHALL not be written.
REQ-025 A good packet arriving with fill = depth and no pop in that cycle SHALL be dropped and SHALL set overflow.
REQ-026 Simultaneous push and pop SHALL both occur at any fill, including full; fill is then unchanged and overflow is not set.
REQ-027 A pop SHALL occur when out_valid && out_ready; out_ready with out_valid low SHALL have no effect.
REQ-028 clear_errors SHALL clear overflow; if a new overflow occurs in the same cycle, set SHALL win.
REQ-029 Read and write pointers SHALL wrap modulo depth; fill SHALL never exceed depth or underflow.
REQ-030 rx_bit_ready strobes with no following rx_packet_complete SHALL hold state indefinitely; there is no internal timeout.

Reset
REQ-031 While rst = 0: state = IDLE, bit_cnt = 0, shift register = 0, pointers = 0, fill = 0, out_valid = 0, out_data = 0, frame_error = 0, overflow = 0.
REQ-032 Reset asserted mid-packet or with the FIFO non-empty SHALL discard all content; no frame_error is generated for the lost packet.

Structure
REQ-033 The assembler state typedef (IDLE/COLLECT/DISCARD) SHALL live in shared package uart_pkg, alongside the receiver's state typedef.
REQ-034 The FIFO SHALL be a sub-module sync_fifo (parameters width, depth) with push/pop/full/empty/fill; the assembler stays in uart_rx_buffer.

Verification
REQ-035 Bits 0,1,0,1,0,0,1,1 (LSB first) then a good completion -> out_data = 0xCA, out_valid high 2 cycles after the completion, frame_error = 0.
REQ-036 8 bits then completion with rx_packet_successfull = 0 -> frame_error pulses once, fill stays 0.
REQ-037 7 bits, or 9 bits, then a good completion -> frame_error pulses once, no write; the next good 8-bit packet 0x55 is stored correctly.
REQ-038 depth = 4, out_ready = 0, five good packets 0x01..0x05 -> fill = 4, overflow = 1, draining yields 0x01..0x04; clear_errors -> overflow = 0.
REQ-039 FIFO full, good packet write coincident with a pop -> fill stays 4, overflow stays 0, order preserved.
REQ-040 rst driven low after 4 bits with 2 words buffered -> out_valid = 0, fill = 0 immediately (asynchronous); after release, a new 8-bit packet 0xA5 is received intact.
